// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_ctrl
// Brief   : programmable divide-by-D tick generator with Gray-coded tick count
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int DIV_W   = 4,
  parameter int GREY_W  = 6,
  parameter int DIV_RST = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  input  logic              start,
  input  logic              stop,
  output logic              incr,
  output logic [GREY_W-1:0] grey,
  output logic              wrap,
  output logic              busy,
  output logic              err_cfg
);

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_run       = 2'd1;
  localparam logic [1:0] c_st_stop_pend = 2'd2;

  localparam logic [DIV_W-1:0]  c_div_rst = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0]  c_div_min = DIV_W'(2);
  localparam logic [DIV_W-1:0]  c_div_one = DIV_W'(1);
  localparam logic [GREY_W-1:0] c_grey_one = GREY_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DIV_W-1:0]  r_ph;
  logic [DIV_W-1:0]  r_div;
  logic [GREY_W-1:0] r_grey;
  logic [GREY_W-1:0] w_grey_bin_inc;
  logic [GREY_W-1:0] w_grey_nxt;
  logic              r_incr;
  logic              r_wrap;
  logic              r_err_cfg;
  logic              w_idle;
  logic              w_cfg_acc;
  logic              w_cfg_ok;
  logic              w_period_end;

  function automatic logic [GREY_W-1:0] gray2bin(input logic [GREY_W-1:0] g);
    logic [GREY_W-1:0] b;
    b[GREY_W-1] = g[GREY_W-1];
    for (int i = GREY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_idle       = (r_state == c_st_idle);
  assign w_cfg_acc    = cfg_valid & w_idle;
  assign w_cfg_ok     = (cfg_div >= c_div_min);
  // div is frozen outside IDLE, so ph never exceeds div-1 and cannot overflow
  assign w_period_end = ~w_idle & (r_ph == (r_div - c_div_one));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      c_st_idle: begin
        if (start) w_state_nxt = c_st_run;
      end
      c_st_run: begin
        if (stop) w_state_nxt = c_st_stop_pend;
      end
      c_st_stop_pend: begin
        // a late start wins over completing the stop on the same edge
        if (start)             w_state_nxt = c_st_run;
        else if (w_period_end) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    busy      = ~w_idle;
    cfg_ready = w_idle;
  end

  // ---- phase counter, ratio register and tick pulse ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ph      <= '0;
      r_div     <= c_div_rst;
      r_incr    <= 1'b0;
      r_err_cfg <= 1'b0;
    end else begin
      r_incr    <= w_period_end;
      r_err_cfg <= w_cfg_acc & ~w_cfg_ok;
      if (w_cfg_acc && w_cfg_ok) r_div <= cfg_div;
      if (w_idle) begin
        if (start) r_ph <= '0;
      end else if (w_period_end) begin
        r_ph <= '0;
      end else begin
        r_ph <= r_ph + c_div_one;
      end
    end
  end

  // ---- Gray tick count ----
  assign w_grey_bin_inc = gray2bin(r_grey) + c_grey_one;
  assign w_grey_nxt     = w_grey_bin_inc ^ (w_grey_bin_inc >> 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grey <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= r_incr & (w_grey_nxt == '0);
      if (r_incr) r_grey <= w_grey_nxt;
    end
  end

  assign incr    = r_incr;
  assign grey    = r_grey;
  assign wrap    = r_wrap;
  assign err_cfg = r_err_cfg;

endmodule
`default_nettype wire
